// File: rtl/data_mem_resp.sv
`timescale 1ns/1ps
// Word-addressed data memory responder: services decoder load/store requests with a fixed
// stall latency, returns registered load data and a fault pulse in the DONE cycle.
module data_mem_resp #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_write;
    logic              r_both;
    logic              w_accept;
    logic              w_req;

    logic [31:0]       w_acc_addr;
    logic              w_acc_write;
    logic              w_acc_both;
    logic [AW-1:0]     w_idx;
    logic              w_fault;
    logic [31:0]       w_rdata_next;
    logic              w_err_next;
    logic              w_enter_done;
    logic              w_commit;

    logic [31:0]       mem [DEPTH_WORDS];

    assign w_req = mem_read_i | mem_write_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, counter and stall
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        stall_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    stall_o      = 1'b1;
                    w_accept     = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_next_state = (LATENCY > 1) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                stall_o    = 1'b1;
                w_cnt_next = r_cnt - CNT_W'(1);
                if (!w_req) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // In IDLE the access being accepted is still on the inputs (LATENCY=1 goes straight to DONE)
    assign w_acc_addr  = (r_state == S_IDLE) ? addr_i      : r_addr;
    assign w_acc_write = (r_state == S_IDLE) ? mem_write_i : r_write;
    assign w_acc_both  = (r_state == S_IDLE) ? (mem_read_i & mem_write_i) : r_both;

    assign w_idx        = w_acc_addr[AW+1:2];
    assign w_fault      = (|w_acc_addr[1:0]) | (|w_acc_addr[31:AW+2]);
    assign w_rdata_next = (!w_acc_write && !w_fault) ? mem[w_idx] : 32'd0;
    assign w_err_next   = w_fault | w_acc_both;
    assign w_enter_done = (w_next_state == S_DONE);
    assign w_commit     = (r_state == S_DONE) && r_write && !w_fault;

    // Request latch and registered response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_both  <= 1'b0;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_write <= mem_write_i;
                r_both  <= mem_read_i & mem_write_i;
            end
            rdata_o <= w_enter_done ? w_rdata_next : 32'd0;
            err_o   <= w_enter_done ? w_err_next : 1'b0;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            mem[w_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
`timescale 1ns/1ps
// Bench for data_mem_resp: one LATENCY=2 and one LATENCY=1 instance, directed cases then
// random accesses checked against an address-keyed reference memory.
module tb_data_mem_resp;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        err   [2];

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH_WORDS(256), .LATENCY(LAT0)) u_dut_l2 (
        .clk_i(clk), .rst_n_i(rst_n), .mem_read_i(rd[0]), .mem_write_i(wr[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .stall_o(stall[0]),
        .err_o(err[0])
    );

    data_mem_resp #(.DEPTH_WORDS(256), .LATENCY(LAT1)) u_dut_l1 (
        .clk_i(clk), .rst_n_i(rst_n), .mem_read_i(rd[1]), .mem_write_i(wr[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .stall_o(stall[1]),
        .err_o(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access from the next IDLE cycle; checks stall length, err and load data
    task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input string name);
        bit          fault;
        int          n;
        int          key;
        int          exp_lat;
        logic [31:0] exp_rd;
        bit          known;
        string       tag;
        fault   = (a % 4 != 0) || (a >= 32'd1024);
        key     = d * 1024 + int'(a / 4 % 256);
        exp_lat = (d == 0) ? LAT0 : LAT1;
        tag     = $sformatf("d%0d %s a=%h", d, name, a);
        @(negedge clk);
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
        #1;
        n = 0;
        while (stall[d] === 1'b1 && n <= 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({tag, " stall_cycles"}, 32'(n), 32'(exp_lat));
        chk({tag, " err"}, 32'(err[d]), 32'(fault || (r && w)));
        known = 1'b1;
        if (w || fault)          exp_rd = 32'd0;
        else if (mdl.exists(key)) exp_rd = mdl[key];
        else begin
            exp_rd = 32'd0;
            known  = 1'b0;
        end
        if (known) chk({tag, " rdata"}, rdata[d], exp_rd);
        rd[d] = 1'b0; wr[d] = 1'b0;
        if (w && !fault) mdl[key] = wd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          sel;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        @(negedge clk);
        #1;
        chk("reset rdata", rdata[0], 32'd0);
        chk("reset err", 32'(err[0]), 32'd0);
        chk("reset stall idle", 32'(stall[0]), 32'd0);
        rd[0] = 1'b1;
        #1;
        chk("reset stall with request", 32'(stall[0]), 32'd1);
        rd[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic store then load
        access(0, 0, 1, 32'h10, 32'hDEADBEEF, "sw");
        access(0, 1, 0, 32'h10, 32'h0, "lw");
        access(1, 0, 1, 32'h0, 32'h12345678, "sw");
        access(1, 1, 0, 32'h0, 32'h0, "lw");

        // Faults leave memory untouched
        access(0, 0, 1, 32'h0, 32'h11111111, "sw");
        access(0, 1, 0, 32'h13, 32'h0, "lw misaligned");
        access(0, 0, 1, 32'h400, 32'hBAD0BAD0, "sw out_of_range");
        access(0, 0, 1, 32'h2, 32'hBAD1BAD1, "sw misaligned");
        access(0, 1, 0, 32'h0, 32'h0, "lw after faults");

        // Both requests: write wins and flags err
        access(0, 1, 1, 32'h20, 32'hA5A5A5A5, "both");
        access(0, 1, 0, 32'h20, 32'h0, "lw after both");

        // Reset during WAIT drops the pending store
        access(0, 0, 1, 32'h30, 32'hCAFE0001, "sw");
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h0BADF00D;
        @(negedge clk);
        #1;
        chk("midreset wait stall", 32'(stall[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset rdata", rdata[0], 32'd0);
        chk("midreset err", 32'(err[0]), 32'd0);
        chk("midreset stall with request", 32'(stall[0]), 32'd1);
        wr[0] = 1'b0;
        #1;
        chk("midreset stall idle", 32'(stall[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1, 0, 32'h30, 32'h0, "lw after midreset");

        // Withdrawn request in WAIT aborts without writing
        access(0, 0, 1, 32'h40, 32'h40404040, "sw");
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hFFFF0000;
        @(negedge clk);
        #1;
        chk("withdraw wait stall", 32'(stall[0]), 32'd1);
        wr[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("withdraw idle stall", 32'(stall[0]), 32'd0);
        chk("withdraw err", 32'(err[0]), 32'd0);
        chk("withdraw rdata", rdata[0], 32'd0);
        access(0, 1, 0, 32'h40, 32'h0, "lw after withdraw");

        // Random back-to-back traffic
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                a = 32'($urandom_range(0, 15)) * 32'd4;
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      a = a + 32'($urandom_range(1, 3));
                else if (sel == 1) a = a + (32'd1 << $urandom_range(10, 31));
                sel = int'($urandom_range(0, 5));
                if (sel <= 2)      access(d, 1, 0, a, 32'h0, "rnd lw");
                else if (sel <= 4) access(d, 0, 1, a, $urandom, "rnd sw");
                else               access(d, 1, 1, a, $urandom, "rnd both");
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
